// File: rtl/controle_pisca_leds.sv
// controle_pisca_leds
// LED blink sequencer: a single start pulse shows a latched 4-bit mask for
// N_PISCAS lit phases of T_ON cycles each, separated by T_OFF-cycle dark
// phases, then pulses fim for one cycle. cancelar or reset abort silently.
`timescale 1ns/1ps

module controle_pisca_leds #(
    parameter int unsigned T_ON     = 3,
    parameter int unsigned T_OFF    = 2,
    parameter int unsigned N_PISCAS = 2,
    parameter int unsigned W_CNT    = 16,
    parameter int unsigned W_N      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       cancelar,
    input  logic [3:0] padrao,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       fim,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        ACESO   = 3'd1,
        APAGADO = 3'd2,
        FIM     = 3'd3
    } estado_t;

    localparam logic [W_CNT-1:0] TIMER_FIM_ACESO   = W_CNT'(T_ON - 1);
    localparam logic [W_CNT-1:0] TIMER_FIM_APAGADO = W_CNT'(T_OFF - 1);
    localparam logic [W_N-1:0]   ALVO_PISCAS       = W_N'(N_PISCAS);

    estado_t          estado, estadoProx;
    logic [W_CNT-1:0] timer, timerProx;
    logic [W_N-1:0]   contagem, contagemProx;
    logic [W_N-1:0]   contagemInc;
    logic [3:0]       mascara, mascaraProx;

    // State, phase timer, blink counter and latched mask registers
    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= OCIOSO;
            timer    <= '0;
            contagem <= '0;
            mascara  <= '0;
        end else begin
            estado   <= estadoProx;
            timer    <= timerProx;
            contagem <= contagemProx;
            mascara  <= mascaraProx;
        end
    end

    // Next-state and datapath update; cancelar overrides everything outside OCIOSO
    always_comb begin
        estadoProx   = estado;
        timerProx    = timer;
        contagemProx = contagem;
        mascaraProx  = mascara;
        contagemInc  = contagem + W_N'(1);

        if (cancelar && (estado != OCIOSO)) begin
            estadoProx   = OCIOSO;
            timerProx    = '0;
            contagemProx = '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (iniciar && !cancelar) begin
                        estadoProx   = ACESO;
                        timerProx    = '0;
                        contagemProx = '0;
                        mascaraProx  = padrao;
                    end
                end
                ACESO: begin
                    if (timer == TIMER_FIM_ACESO) begin
                        timerProx    = '0;
                        contagemProx = contagemInc;
                        estadoProx   = (contagemInc == ALVO_PISCAS) ? FIM : APAGADO;
                    end else begin
                        timerProx = timer + W_CNT'(1);
                    end
                end
                APAGADO: begin
                    if (timer == TIMER_FIM_APAGADO) begin
                        timerProx  = '0;
                        estadoProx = ACESO;
                    end else begin
                        timerProx = timer + W_CNT'(1);
                    end
                end
                FIM: begin
                    estadoProx   = OCIOSO;
                    timerProx    = '0;
                    contagemProx = '0;
                end
                default: begin
                    estadoProx   = OCIOSO;
                    timerProx    = '0;
                    contagemProx = '0;
                end
            endcase
        end
    end

    // Moore output decode from registered state and mask
    always_comb begin
        leds      = '0;
        ocupado   = 1'b0;
        fim       = 1'b0;
        db_estado = estado;
        case (estado)
            ACESO: begin
                leds    = mascara;
                ocupado = 1'b1;
            end
            APAGADO: ocupado = 1'b1;
            FIM: begin
                ocupado = 1'b1;
                fim     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_controle_pisca_leds.sv
// Directed testbench for controle_pisca_leds (default parameters plus a
// single-blink instance). Inputs change and outputs are sampled on the
// falling clock edge.
`timescale 1ns/1ps

module tb_controle_pisca_leds;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar, cancelar;
    logic [3:0] padrao;
    logic [3:0] leds;
    logic       ocupado, fim;
    logic [2:0] db_estado;

    logic       iniciar1, cancelar1;
    logic [3:0] padrao1;
    logic [3:0] leds1;
    logic       ocupado1, fim1;
    logic [2:0] db_estado1;

    int passed = 0;
    int total  = 0;

    // Expected state code per cycle after an accepted iniciar
    logic [2:0] seqN2 [0:9] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd3, 3'd0};
    logic [2:0] seqN1 [0:4] = '{3'd1, 3'd1, 3'd1, 3'd3, 3'd0};

    logic [2:0] expE;
    logic [3:0] expL;
    logic       expF, expO;

    always #5 clock = ~clock;

    controle_pisca_leds dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .cancelar(cancelar),
        .padrao(padrao), .leds(leds), .ocupado(ocupado), .fim(fim),
        .db_estado(db_estado)
    );

    controle_pisca_leds #(.N_PISCAS(1)) dut1 (
        .clock(clock), .reset(reset), .iniciar(iniciar1), .cancelar(cancelar1),
        .padrao(padrao1), .leds(leds1), .ocupado(ocupado1), .fim(fim1),
        .db_estado(db_estado1)
    );

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        total++;
        if ({db_estado, leds, fim, ocupado} !== {3'd0, 4'b0000, 1'b0, 1'b0})
            $display("FAIL reset: got db=%0d leds=%b fim=%b ocupado=%b, expected db=0 leds=0000 fim=0 ocupado=0",
                     db_estado, leds, fim, ocupado);
        else passed++;
        reset = 1'b0;
        @(negedge clock);
        total++;
        if ({db_estado, leds, fim, ocupado} !== {3'd0, 4'b0000, 1'b0, 1'b0})
            $display("FAIL reset_idle: got db=%0d leds=%b fim=%b ocupado=%b, expected db=0 leds=0000 fim=0 ocupado=0",
                     db_estado, leds, fim, ocupado);
        else passed++;
        total++;
        if ({db_estado1, leds1, fim1, ocupado1} !== {3'd0, 4'b0000, 1'b0, 1'b0})
            $display("FAIL reset_n1: got db=%0d leds=%b fim=%b ocupado=%b, expected db=0 leds=0000 fim=0 ocupado=0",
                     db_estado1, leds1, fim1, ocupado1);
        else passed++;
    endtask

    task automatic test_sequence(input logic [3:0] mask);
        iniciar = 1'b1;
        padrao  = mask;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            iniciar = 1'b0;
            expE = seqN2[i];
            expL = (expE == 3'd1) ? mask : 4'b0000;
            expF = (expE == 3'd3);
            expO = (expE != 3'd0);
            total++;
            if ({db_estado, leds, fim, ocupado} !== {expE, expL, expF, expO})
                $display("FAIL seq mask=%b cycle %0d: got db=%0d leds=%b fim=%b ocupado=%b, expected db=%0d leds=%b fim=%b ocupado=%b",
                         mask, i + 1, db_estado, leds, fim, ocupado, expE, expL, expF, expO);
            else passed++;
        end
    endtask

    task automatic test_ignore_iniciar();
        iniciar = 1'b1;
        padrao  = 4'b1010;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            iniciar = 1'b0;
            expE = seqN2[i];
            expL = (expE == 3'd1) ? 4'b1010 : 4'b0000;
            expF = (expE == 3'd3);
            expO = (expE != 3'd0);
            total++;
            if ({db_estado, leds, fim, ocupado} !== {expE, expL, expF, expO})
                $display("FAIL ignore cycle %0d: got db=%0d leds=%b fim=%b ocupado=%b, expected db=%0d leds=%b fim=%b ocupado=%b",
                         i + 1, db_estado, leds, fim, ocupado, expE, expL, expF, expO);
            else passed++;
            if (i == 3) begin
                padrao  = 4'b0101;
                iniciar = 1'b1;
            end
        end
    endtask

    task automatic test_cancel();
        iniciar = 1'b1;
        padrao  = 4'b1010;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            iniciar = 1'b0;
            expE = seqN2[i];
            expL = (expE == 3'd1) ? 4'b1010 : 4'b0000;
            total++;
            if ({db_estado, leds} !== {expE, expL})
                $display("FAIL cancel_pre cycle %0d: got db=%0d leds=%b, expected db=%0d leds=%b",
                         i + 1, db_estado, leds, expE, expL);
            else passed++;
        end
        cancelar = 1'b1;
        @(negedge clock);
        cancelar = 1'b0;
        total++;
        if ({db_estado, leds, fim, ocupado} !== {3'd0, 4'b0000, 1'b0, 1'b0})
            $display("FAIL cancel: got db=%0d leds=%b fim=%b ocupado=%b, expected db=0 leds=0000 fim=0 ocupado=0",
                     db_estado, leds, fim, ocupado);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total++;
            if ({db_estado, fim} !== {3'd0, 1'b0})
                $display("FAIL cancel_nofim cycle %0d: got db=%0d fim=%b, expected db=0 fim=0", i, db_estado, fim);
            else passed++;
        end
        test_sequence(4'b1111);
    endtask

    task automatic test_reset_mid();
        iniciar = 1'b1;
        padrao  = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            iniciar = 1'b0;
        end
        total++;
        if (db_estado !== 3'd2)
            $display("FAIL reset_mid_pre: got db=%0d, expected db=2", db_estado);
        else passed++;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        total++;
        if ({db_estado, leds, fim, ocupado} !== {3'd0, 4'b0000, 1'b0, 1'b0})
            $display("FAIL reset_mid: got db=%0d leds=%b fim=%b ocupado=%b, expected db=0 leds=0000 fim=0 ocupado=0",
                     db_estado, leds, fim, ocupado);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            total++;
            if ({db_estado, fim} !== {3'd0, 1'b0})
                $display("FAIL reset_mid_nofim cycle %0d: got db=%0d fim=%b, expected db=0 fim=0", i, db_estado, fim);
            else passed++;
        end
    endtask

    task automatic test_start_cancel_idle();
        iniciar  = 1'b1;
        cancelar = 1'b1;
        padrao   = 4'b0011;
        @(negedge clock);
        iniciar  = 1'b0;
        cancelar = 1'b0;
        total++;
        if ({db_estado, leds, ocupado} !== {3'd0, 4'b0000, 1'b0})
            $display("FAIL start_cancel_idle: got db=%0d leds=%b ocupado=%b, expected db=0 leds=0000 ocupado=0",
                     db_estado, leds, ocupado);
        else passed++;
        @(negedge clock);
        total++;
        if (db_estado !== 3'd0)
            $display("FAIL start_cancel_idle_hold: got db=%0d, expected db=0", db_estado);
        else passed++;
    endtask

    task automatic test_single_blink();
        iniciar1 = 1'b1;
        padrao1  = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            iniciar1 = 1'b0;
            expE = seqN1[i];
            expL = (expE == 3'd1) ? 4'b0110 : 4'b0000;
            expF = (expE == 3'd3);
            expO = (expE != 3'd0);
            total++;
            if ({db_estado1, leds1, fim1, ocupado1} !== {expE, expL, expF, expO})
                $display("FAIL single_blink cycle %0d: got db=%0d leds=%b fim=%b ocupado=%b, expected db=%0d leds=%b fim=%b ocupado=%b",
                         i + 1, db_estado1, leds1, fim1, ocupado1, expE, expL, expF, expO);
            else passed++;
        end
    endtask

    initial begin
        reset     = 1'b0;
        iniciar   = 1'b0;
        cancelar  = 1'b0;
        padrao    = 4'b0000;
        iniciar1  = 1'b0;
        cancelar1 = 1'b0;
        padrao1   = 4'b0000;

        test_reset();
        test_sequence(4'b1010);
        test_ignore_iniciar();
        test_cancel();
        test_reset_mid();
        test_start_cancel_idle();
        test_single_blink();
        test_sequence(4'b0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
